// File: rtl/instr_line_mem.sv
// Instruction line-fill memory: a word-writable backing store returning whole
// 128-bit lines a fixed number of cycles after a request is accepted.
module instr_line_mem #(
    parameter int LATENCY = 4,
    parameter int LINES   = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [127:0] resp_line,
    output logic [31:0]  resp_addr,
    input  logic         wr_en,
    input  logic [31:0]  wr_addr,
    input  logic [31:0]  wr_data,
    output logic [1:0]   dbg_state
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_valid while req_ready is 0 is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q;
    logic        accept;
    logic        enter_resp;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [127:0] rd_line;
    logic         unused_bits;

    // Backing store is word-organised; starts at zero and is never cleared.
    logic [31:0] mem [LINES*4] = '{default: '0};

    assign req_ready   = (state == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign enter_resp  = (state == WAIT) && (cnt == 4'd0);
    assign resp_valid  = (state == RESP);
    assign dbg_state   = state;
    assign rd_idx      = addr_q[IDX_W+3:4];
    assign wr_idx      = wr_addr[IDX_W+3:4];
    assign unused_bits = ^{req_addr[3:0], wr_addr[1:0], wr_addr[31:IDX_W+4]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write landing on the same edge as the read is forwarded into the line.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < 4; k++) begin
            if (wr_en && (wr_idx == rd_idx) && (wr_addr[3:2] == 2'(k))) begin
                rd_line[32*k +: 32] = wr_data;
            end else begin
                rd_line[32*k +: 32] = mem[{rd_idx, 2'(k)}];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            resp_line <= '0;
            resp_addr <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= {req_addr[31:4], 4'b0000};
            end
            if (enter_resp) begin
                resp_line <= rd_line;
                resp_addr <= addr_q;
            end
        end
    end

    // Loader writes are honoured in every state, including during reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_idx, wr_addr[3:2]}] <= wr_data;
        end
    end

endmodule
